// File: rtl/sort_memory.sv
// Word-addressed RAM with a held read/write request, programmable completion
// latency and a single-cycle side load port used to preload the array.
module sort_memory #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q, op_addr;
  logic [DATA_W-1:0] wdata_q, op_wdata;
  logic              rd_q, op_rd;
  logic              accept, commit, op_in_rng, ld_in_rng, load;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (read || write) state_nx = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == CW'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The operation in flight; with LATENCY=1 it commits on its own acceptance
  // edge, so the live inputs are used before the latches are loaded.
  assign accept    = (state == IDLE) && (read || write);
  assign op_addr   = accept ? addr  : addr_q;
  assign op_wdata  = accept ? wdata : wdata_q;
  assign op_rd     = accept ? read  : rd_q;
  assign commit    = (state_nx == RESP) && (state != RESP);
  assign op_in_rng = {1'b0, op_addr} < (ADDR_W+1)'(DEPTH);
  assign ld_in_rng = {1'b0, ld_addr} < (ADDR_W+1)'(DEPTH);
  assign load      = (state == IDLE) && !read && !write && ld_en && ld_in_rng;

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= read;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && op_rd)
        rdata <= op_in_rng ? mem[op_addr[IW-1:0]] : '0;
    end

  // Array contents survive reset; reset only blocks writes while asserted.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
    end else if (commit && !op_rd && op_in_rng) begin
      mem[op_addr[IW-1:0]] <= op_wdata;
    end else if (load) begin
      mem[ld_addr[IW-1:0]] <= ld_data;
    end
endmodule
